// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, issues one word read per
//               cycle, and buffers returned words in a 2-entry queue for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              i_run,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_busy
);

  typedef enum logic [0:0] {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_infl;
  logic [ADDR_W-1:0]   r_infl_pc;
  logic [DATA_W-1:0]   r_q_data [2];
  logic [ADDR_W-1:0]   r_q_pc   [2];
  logic [1:0]          r_count;

  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  logic [1:0]          w_occ;
  logic [1:0]          w_fill;
  logic                w_wr_idx;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= ST_HALT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_occ       = 2'd0;
    w_fill      = 2'd0;
    w_wr_idx    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_HALT: if (i_run)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!i_run) w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_HALT;
    endcase
    w_pop    = (r_count != 2'd0) & i_ready;
    w_push   = r_infl & ~i_redirect;
    // Words owed or held after this edge's pop; capped at queue depth.
    w_occ    = r_count + {1'b0, r_infl} - {1'b0, w_pop};
    w_issue  = (r_state == ST_RUN) & ~i_redirect & (w_occ < 2'd2);
    w_fill   = r_count - {1'b0, w_pop};
    w_wr_idx = w_fill[0];
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_pc        <= RESET_PC;
      r_infl      <= 1'b0;
      r_infl_pc   <= '0;
      r_count     <= 2'd0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
    end else begin
      if (w_issue) begin
        r_infl_pc <= r_pc;
      end
      if (i_redirect) begin
        r_pc    <= i_redirect_pc;
        r_infl  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_issue) begin
          r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        r_infl <= w_issue;
        if (w_pop) begin
          r_q_data[0] <= r_q_data[1];
          r_q_pc[0]   <= r_q_pc[1];
        end
        // Push lands after the shift, so a push+pop at depth 1 refills the head.
        if (w_push) begin
          r_q_data[w_wr_idx] <= i_mem_data;
          r_q_pc[w_wr_idx]   <= r_infl_pc;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  assign o_mem_rd   = w_issue;
  assign o_mem_addr = r_pc;
  assign o_valid    = (r_count != 2'd0);
  assign o_instr    = r_q_data[0];
  assign o_instr_pc = r_q_pc[0];
  assign o_busy     = r_infl | (r_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [AW-1:0] ALL1 = '1;

  logic          clk = 1'b0;
  logic          clear_n;
  logic          i_run, i_redirect, i_ready;
  logic [AW-1:0] i_redirect_pc;
  logic          o_mem_rd, o_valid, o_busy;
  logic [AW-1:0] o_mem_addr, o_instr_pc;
  logic [DW-1:0] i_mem_data, o_instr;

  logic          i_run2, i_ready2, i_redirect2;
  logic [AW-1:0] i_redirect_pc2;
  logic          o_mem_rd2, o_valid2, o_busy2;
  logic [AW-1:0] o_mem_addr2, o_instr_pc2;
  logic [DW-1:0] i_mem_data2, o_instr2;

  int n_tests = 0;
  int n_fail  = 0;
  int sb_pops = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
    .clk(clk), .clear_n(clear_n), .i_run(i_run), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr),
    .i_mem_data(i_mem_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_instr(o_instr), .o_instr_pc(o_instr_pc), .o_busy(o_busy)
  );

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(ALL1)) dut2 (
    .clk(clk), .clear_n(clear_n), .i_run(i_run2), .i_redirect(i_redirect2),
    .i_redirect_pc(i_redirect_pc2), .o_mem_rd(o_mem_rd2), .o_mem_addr(o_mem_addr2),
    .i_mem_data(i_mem_data2), .o_valid(o_valid2), .i_ready(i_ready2),
    .o_instr(o_instr2), .o_instr_pc(o_instr_pc2), .o_busy(o_busy2)
  );

  // RAM models: ram[k] = k + 100, one-cycle read latency, poison when idle.
  always @(posedge clk) begin
    i_mem_data  <= o_mem_rd  ? (o_mem_addr  + 64'd100) : 64'hDEAD_BEEF_0BAD_F00D;
    i_mem_data2 <= o_mem_rd2 ? (o_mem_addr2 + 64'd100) : 64'hDEAD_BEEF_0BAD_F00D;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [AW-1:0] exp_q  [$];
  logic [AW-1:0] exp2_q [$];

  task automatic load_exp(input logic [AW-1:0] start);
    exp_q.delete();
    for (int k = 0; k < 256; k++) exp_q.push_back(start + AW'(k));
  endtask

  always @(negedge clk) begin
    if (clear_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: got pc %0h with no expected word", o_instr_pc);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        sb_pops++;
        chk("sb_pc", o_instr_pc, e);
        chk("sb_instr", o_instr, e + 64'd100);
      end
    end
    if (clear_n && o_valid2 && i_ready2 && exp2_q.size() != 0) begin
      logic [AW-1:0] e2;
      e2 = exp2_q.pop_front();
      chk("wrap_pc", o_instr_pc2, e2);
      chk("wrap_instr", o_instr2, e2 + 64'd100);
    end
  end

  typedef struct {
    logic          run;
    logic          ready;
    logic          rd;
    logic [AW-1:0] addr;
    logic          valid;
    logic [AW-1:0] ipc;
    logic          busy;
  } vec_t;

  function automatic vec_t v(input logic run, input logic ready, input logic rd,
                             input int addr, input logic valid, input int ipc,
                             input logic busy);
    vec_t r;
    r.run = run; r.ready = ready; r.rd = rd; r.addr = AW'(addr);
    r.valid = valid; r.ipc = AW'(ipc); r.busy = busy;
    return r;
  endfunction

  vec_t tbl [21];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int pops0;
    // streaming, 5-cycle stall, run drop with a read in flight, resume
    tbl[0]  = v(1,1,0, 0,0,0,0);  tbl[1]  = v(1,1,1, 0,0,0,0);
    tbl[2]  = v(1,1,1, 1,0,0,1);  tbl[3]  = v(1,1,1, 2,1,0,1);
    tbl[4]  = v(1,1,1, 3,1,1,1);  tbl[5]  = v(1,0,0, 4,1,2,1);
    tbl[6]  = v(1,0,0, 4,1,2,1);  tbl[7]  = v(1,0,0, 4,1,2,1);
    tbl[8]  = v(1,0,0, 4,1,2,1);  tbl[9]  = v(1,0,0, 4,1,2,1);
    tbl[10] = v(1,1,1, 4,1,2,1);  tbl[11] = v(1,1,1, 5,1,3,1);
    tbl[12] = v(1,1,1, 6,1,4,1);  tbl[13] = v(0,1,1, 7,1,5,1);
    tbl[14] = v(0,1,0, 8,1,6,1);  tbl[15] = v(0,1,0, 8,1,7,1);
    tbl[16] = v(0,1,0, 8,0,0,0);  tbl[17] = v(1,1,0, 8,0,0,0);
    tbl[18] = v(1,1,1, 8,0,0,0);  tbl[19] = v(1,1,1, 9,0,0,1);
    tbl[20] = v(1,1,1,10,1,8,1);

    clear_n = 1'b0; i_run = 1'b0; i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_run2 = 1'b0; i_ready2 = 1'b1; i_redirect2 = 1'b0; i_redirect_pc2 = '0;
    load_exp('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_rd", o_mem_rd, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_ipc", o_instr_pc, 0);
    chk("rst_addr2", o_mem_addr2, ALL1);
    clear_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      i_run   = tbl[i].run;
      i_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("v%0d_mem_rd", i), o_mem_rd, tbl[i].rd);
      chk($sformatf("v%0d_addr", i), o_mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), o_valid, tbl[i].valid);
      chk($sformatf("v%0d_busy", i), o_busy, tbl[i].busy);
      if (tbl[i].valid) begin
        chk($sformatf("v%0d_ipc", i), o_instr_pc, tbl[i].ipc);
        chk($sformatf("v%0d_instr", i), o_instr, tbl[i].ipc + 64'd100);
      end
      @(posedge clk); #1;
    end

    // Redirect with one word queued and one read in flight.
    i_run = 1'b1; i_ready = 1'b0; i_redirect = 1'b1; i_redirect_pc = 64'h40;
    load_exp(64'h40);
    @(negedge clk);
    chk("redir_no_rd", o_mem_rd, 0);
    chk("redir_head_held", o_instr_pc, 9);
    @(posedge clk); #1;
    i_redirect = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    chk("redir_valid0", o_valid, 0);
    chk("redir_rd", o_mem_rd, 1);
    chk("redir_addr", o_mem_addr, 64'h40);
    chk("redir_busy0", o_busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("redir_lat_valid0", o_valid, 0);
    chk("redir_addr1", o_mem_addr, 64'h41);
    @(posedge clk); #1;
    @(negedge clk);
    chk("redir_lat_valid1", o_valid, 1);
    chk("redir_first_pc", o_instr_pc, 64'h40);
    repeat (6) @(posedge clk);
    #1;

    // PC wrap on the second instance.
    exp2_q.delete();
    exp2_q.push_back(ALL1);
    exp2_q.push_back(64'd0);
    exp2_q.push_back(64'd1);
    i_run2 = 1'b1;
    for (int c = 0; c < 12 && exp2_q.size() != 0; c++) @(posedge clk);
    chk("wrap_all_seen", 64'(exp2_q.size()), 0);
    i_run2 = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-stream.
    #2;
    clear_n = 1'b0;
    #1;
    chk("arst_mem_rd", o_mem_rd, 0);
    chk("arst_addr", o_mem_addr, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_instr", o_instr, 0);
    chk("arst_ipc", o_instr_pc, 0);
    load_exp('0);
    pops0 = sb_pops;
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_restart_rd", o_mem_rd, 1);
    chk("arst_restart_addr", o_mem_addr, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("arst_delivered", 64'(sb_pops - pops0 >= 4), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
